// File: rtl/gcd_pkg.sv
// Shared types and helpers for the binary GCD coprocessor.
// Optional cycle counter is enabled by defining GCD_CYCLE_COUNT_EN.
package gcd_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        REDUCE = 2'b01,
        DONE   = 2'b10
    } state_t;

    // Bits needed to hold any step count up to the worst-case latency 4*width+2.
    function automatic int cnt_width(input int width);
        int n;
        n = 0;
        while ((64'd1 << n) < 64'(4 * width + 3)) begin
            n = n + 1;
        end
        return n;
    endfunction

endpackage

// File: rtl/gcd_step.sv
// One Stein reduction step: priority-ordered terminal checks, then halving or
// subtracting the smaller operand from the larger.
module gcd_step
    import gcd_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] x_next,
    output logic [WIDTH-1:0] y_next,
    output logic             k_inc,
    output logic             done,
    output logic [WIDTH-1:0] raw
);

    always_comb begin
        x_next = x;
        y_next = y;
        k_inc  = 1'b0;
        done   = 1'b0;
        raw    = '0;
        if (x == '0) begin
            done = 1'b1;
            raw  = y;
        end else if (y == '0) begin
            done = 1'b1;
            raw  = x;
        end else if (x == y) begin
            done = 1'b1;
            raw  = x;
        end else if (!x[0] && !y[0]) begin
            x_next = x >> 1;
            y_next = y >> 1;
            k_inc  = 1'b1;
        end else if (!x[0]) begin
            x_next = x >> 1;
        end else if (!y[0]) begin
            y_next = y >> 1;
        end else if (x > y) begin
            x_next = x - y;
        end else begin
            y_next = y - x;
        end
    end

endmodule

// File: rtl/gcd_engine.sv
// Multi-cycle binary GCD coprocessor with valid/ready on both sides.
// Define GCD_CYCLE_COUNT_EN to add the 'cycles' REDUCE-step counter output.
module gcd_engine
    import gcd_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
`ifdef GCD_CYCLE_COUNT_EN
    output logic [CNT_W-1:0] cycles,
`endif
    output logic             busy
);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [CNT_W-1:0] k;
    logic [WIDTH-1:0] x_next;
    logic [WIDTH-1:0] y_next;
    logic             k_inc;
    logic             st_done;
    logic [WIDTH-1:0] st_raw;

    gcd_step #(.WIDTH(WIDTH)) u_step (
        .x      (x),
        .y      (y),
        .x_next (x_next),
        .y_next (y_next),
        .k_inc  (k_inc),
        .done   (st_done),
        .raw    (st_raw)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = REDUCE;
            REDUCE:  if (st_done) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state == REDUCE) || (state == DONE);
    end

    // The common power of two stripped during reduction is restored when latching the result.
    always_ff @(posedge clk) begin
        if (!rst) begin
            x      <= '0;
            y      <= '0;
            k      <= '0;
            result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x <= a;
                        y <= b;
                        k <= '0;
                    end
                end
                REDUCE: begin
                    if (st_done) begin
                        result <= st_raw << k;
                    end else begin
                        x <= x_next;
                        y <= y_next;
                        if (k_inc) k <= k + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef GCD_CYCLE_COUNT_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            cycles <= '0;
        end else if (state == IDLE && in_valid) begin
            cycles <= '0;
        end else if (state == REDUCE) begin
            cycles <= cycles + CNT_W'(1);
        end
    end
`endif

endmodule
